// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous instruction memory and holds the IF/ID register.
// Supports stall, redirect (jump) and halt.
module fetch_stage #(
  parameter int unsigned          PC_BITS   = 10,
  parameter int unsigned          REGI_SIZE = 16,
  parameter logic [REGI_SIZE-1:0] NOP_WORD  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stall_i,
  input  logic                 jump_en_i,
  input  logic [PC_BITS-1:0]   jump_addr_i,
  input  logic                 end_i,
  output logic [PC_BITS-1:0]   imem_addr_o,
  input  logic [REGI_SIZE-1:0] imem_rd_data_i,
  output logic [REGI_SIZE-1:0] instruction_o,
  output logic [REGI_SIZE-1:0] next_pc_o,
  output logic                 valid_o,
  output logic                 halted_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  state_e               state_q, state_d;
  logic [PC_BITS-1:0]   pc_q, pc_d;
  logic [PC_BITS-1:0]   req_pc_q, req_pc_d;
  logic                 req_vld_q, req_vld_d;
  logic [REGI_SIZE-1:0] instr_q, instr_d;
  logic [REGI_SIZE-1:0] next_pc_q, next_pc_d;
  logic                 valid_q, valid_d;

  logic [PC_BITS-1:0]   pc_inc;
  logic [PC_BITS-1:0]   req_pc_inc;

  assign pc_inc     = pc_q + 1'b1;
  assign req_pc_inc = req_pc_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    req_vld_d = req_vld_q;
    instr_d   = instr_q;
    next_pc_d = next_pc_q;
    valid_d   = valid_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StRun;
          pc_d      = '0;
          req_vld_d = 1'b0;
        end
      end
      StRun: begin
        if (jump_en_i) begin
          // The read issued this cycle belongs to the old path and is dropped.
          pc_d      = jump_addr_i;
          req_vld_d = 1'b0;
          valid_d   = 1'b0;
          instr_d   = NOP_WORD;
        end else if (end_i) begin
          state_d   = StHalt;
          req_vld_d = 1'b0;
          valid_d   = 1'b0;
          instr_d   = NOP_WORD;
        end else if (!stall_i) begin
          req_pc_d  = pc_q;
          req_vld_d = 1'b1;
          pc_d      = pc_inc;
          instr_d   = req_vld_q ? imem_rd_data_i : NOP_WORD;
          next_pc_d = REGI_SIZE'(req_pc_inc);
          valid_d   = req_vld_q;
        end
      end
      StHalt: begin
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      req_pc_q  <= '0;
      req_vld_q <= 1'b0;
      instr_q   <= NOP_WORD;
      next_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      req_vld_q <= req_vld_d;
      instr_q   <= instr_d;
      next_pc_q <= next_pc_d;
      valid_q   <= valid_d;
    end
  end

  // While stalled, re-issue the in-flight address so its data is still presented afterwards.
  assign imem_addr_o   = (state_q == StRun && stall_i) ? req_pc_q : pc_q;
  assign instruction_o = instr_q;
  assign next_pc_o     = next_pc_q;
  assign valid_o       = valid_q;
  assign halted_o      = (state_q == StHalt);

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL take parameter PC_BITS, default 10, as the instruction-address width, matching the decode jumpAddress width.
REQ-002 The block SHALL take parameter REGI_SIZE, default 16, as the instruction and PC data width.
REQ-003 The block SHALL take parameter NOP_WORD, default 16'h0000, as the instruction word driven on bubbles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port start_i, input, 1 bit: a pulse that begins fetching at address 0 from IDLE.
REQ-007 The block SHALL have port stall_i, input, 1 bit: freezes the fetch and the IF/ID register.
REQ-008 The block SHALL have port jump_en_i, input, 1 bit: redirect request from execute.
REQ-009 The block SHALL have port jump_addr_i, input, PC_BITS: the redirect target.
REQ-010 The block SHALL have port end_i, input, 1 bit: the decode flagEnd indication.
REQ-011 The block SHALL have port imem_addr_o, output, PC_BITS: the synchronous instruction-memory read address.
REQ-012 The block SHALL have port imem_rd_data_i, input, REGI_SIZE: memory data, valid one cycle after its address.
REQ-013 The block SHALL have port instruction_o, output, REGI_SIZE: the IF/ID instruction to decode.
REQ-014 The block SHALL have port next_pc_o, output, REGI_SIZE: the zero-extended PC+1 of instruction_o.
REQ-015 The block SHALL have port valid_o, output, 1 bit: instruction_o holds a real instruction.
REQ-016 The block SHALL have port halted_o, output, 1 bit: high while in HALT.

Function
REQ-017 The state machine SHALL have three states, IDLE, RUN and HALT; IDLE->RUN on start_i, RUN->HALT on end_i (unless jump_en_i), HALT exits only via reset.
REQ-018 Internal state SHALL be pc (fetch address), req_pc (address of the in-flight read) and req_vld.
REQ-019 imem_addr_o SHALL equal req_pc when stall_i=1 in RUN, else pc, so a stalled read is re-issued and its data is not lost.
REQ-020 In a RUN cycle with no stall, jump or end: req_pc<=pc, req_vld<=1, pc<=pc+1 mod 2^PC_BITS, instruction_o<=imem_rd_data_i, next_pc_o<=zero-extend(req_pc+1 mod 2^PC_BITS), valid_o<=req_vld.
REQ-021 When a bubble is loaded (valid_o<=0), instruction_o SHALL be loaded with NOP_WORD.
REQ-022 On stall_i=1 in RUN with no jump or end, pc, req_pc, req_vld, instruction_o, next_pc_o and valid_o SHALL all hold.
REQ-023 On jump_en_i=1 in RUN: pc<=jump_addr_i, req_vld<=0, valid_o<=0, instruction_o<=NOP_WORD, regardless of stall_i.
REQ-024 After a jump asserted in cycle t, valid_o SHALL be 0 in t+1 and t+2, and instruction_o=mem[J] with valid_o=1 in t+3 absent stalls.
REQ-025 Priority SHALL be jump_en_i > end_i > stall_i; end_i in the same cycle as jump_en_i is ignored.
REQ-026 On end_i=1 in RUN without a jump: next state HALT, valid_o<=0, instruction_o<=NOP_WORD, pc holds.
REQ-027 In IDLE and HALT, valid_o SHALL be 0, pc SHALL hold, imem_addr_o=pc, and jump_en_i, stall_i and end_i SHALL be ignored.
REQ-028 On start_i in IDLE: pc<=0, req_vld<=0, and the first valid instruction (address 0) appears two cycles after RUN entry.
REQ-029 A pc increment past 2^PC_BITS-1 SHALL wrap to 0; next_pc_o for address 1023 SHALL be 16'h0000.

Reset
REQ-030 While rst=0, asynchronously: state=IDLE, pc=0, req_pc=0, req_vld=0, instruction_o=NOP_WORD, next_pc_o=0, valid_o=0, halted_o=0, imem_addr_o=0.
REQ-031 Reset asserted mid-operation (RUN, stalled or HALT) SHALL discard all in-flight fetches, and fetching SHALL resume only after a new start_i.

Verification
REQ-032 Sequential run: ROM mem[i]=16'hA000+i, start_i pulse -> valid_o rises 2 cycles after RUN entry, instruction_o A000, A001, A002 with next_pc_o 1, 2, 3 on consecutive cycles.
REQ-033 Stall: assert stall_i for 3 cycles while instruction_o=A005 -> outputs hold A005/6 for 3 cycles, then A006 follows with no skip or duplicate.
REQ-034 Jump: jump_en_i=1, jump_addr_i=10'h200 with stall_i=1 in cycle t -> valid_o=0 at t+1 and t+2, instruction_o=mem[0x200], next_pc_o=0x201 at t+3.
REQ-035 Same-cycle jump_en_i and end_i -> no HALT, redirect taken; a later lone end_i -> halted_o=1, valid_o=0, instruction_o=NOP_WORD, and a subsequent jump_en_i is ignored.
REQ-036 Wrap: jump to 0x3FE -> instructions 0x3FE, 0x3FF, 0x000 in order with next_pc_o 0x3FF, 0x000, 0x001; rst pulsed low mid-run -> all outputs reach reset values before the next clock edge.
